// File: rtl/jesd204_soft_pcs_rx_sync_ctrl.sv
// Per-lane 8b10b code-group synchronisation controller for the soft RX PCS.
// Locks each lane on a run of clean K28.5 beats and requests comma realignment while any enabled lane is unaligned.
module jesd204_soft_pcs_rx_sync_ctrl #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int LOCK_COUNT      = 4,
    parameter int ERR_THRESHOLD   = 3,
    parameter int GOOD_RUN        = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_LANES-1:0]                 enable,
    input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] char,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] charisk,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] notintable,
    input  logic [NUM_LANES*DATA_PATH_WIDTH-1:0] disperr,
    output logic                                 patternalign_en,
    output logic [NUM_LANES-1:0]                 lane_aligned,
    output logic                                 all_aligned,
    output logic [NUM_LANES-1:0]                 align_lost,
    output logic [NUM_LANES*3-1:0]               err_count
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);
    localparam logic [2:0] ERR_MAX  = 3'(ERR_THRESHOLD);
    localparam logic [3:0] GOOD_MAX = 4'(GOOD_RUN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    logic unaligned_any;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        state_t     state, state_nxt;
        logic [3:0] lock_cnt, lock_cnt_nxt;
        logic [3:0] good_cnt, good_cnt_nxt;
        logic [2:0] err_cnt, err_cnt_nxt;
        logic       lost_q, lost_nxt;
        logic       err_beat, comma_beat;

        // A beat is a comma only if every octet is a K28.5 and nothing in it decoded badly.
        always_comb begin
            err_beat   = 1'b0;
            comma_beat = 1'b1;
            for (int o = 0; o < DATA_PATH_WIDTH; o++) begin
                err_beat   = err_beat | notintable[l*DATA_PATH_WIDTH+o] | disperr[l*DATA_PATH_WIDTH+o];
                comma_beat = comma_beat & charisk[l*DATA_PATH_WIDTH+o]
                             & (char[(l*DATA_PATH_WIDTH+o)*8 +: 8] == 8'hBC);
            end
            comma_beat = comma_beat & ~err_beat;
        end

        always_comb begin
            state_nxt    = state;
            lock_cnt_nxt = lock_cnt;
            good_cnt_nxt = good_cnt;
            err_cnt_nxt  = err_cnt;
            lost_nxt     = 1'b0;
            if (!enable[l]) begin
                state_nxt    = ST_IDLE;
                lock_cnt_nxt = 4'd0;
                good_cnt_nxt = 4'd0;
                err_cnt_nxt  = 3'd0;
            end else begin
                case (state)
                    ST_IDLE: state_nxt = ST_SEARCH;
                    ST_SEARCH: begin
                        if (comma_beat) begin
                            state_nxt    = ST_CHECK;
                            lock_cnt_nxt = 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (!comma_beat) begin
                            state_nxt    = ST_SEARCH;
                            lock_cnt_nxt = 4'd0;
                        end else if (lock_cnt + 4'd1 == LOCK_MAX) begin
                            state_nxt    = ST_LOCKED;
                            lock_cnt_nxt = 4'd0;
                            err_cnt_nxt  = 3'd0;
                            good_cnt_nxt = 4'd0;
                        end else begin
                            lock_cnt_nxt = lock_cnt + 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (err_beat) begin
                            good_cnt_nxt = 4'd0;
                            if (err_cnt + 3'd1 == ERR_MAX) begin
                                state_nxt   = ST_SEARCH;
                                err_cnt_nxt = 3'd0;
                                lost_nxt    = 1'b1;
                            end else begin
                                err_cnt_nxt = err_cnt + 3'd1;
                            end
                        end else if (good_cnt + 4'd1 == GOOD_MAX) begin
                            good_cnt_nxt = 4'd0;
                            if (err_cnt != 3'd0) err_cnt_nxt = err_cnt - 3'd1;
                        end else begin
                            good_cnt_nxt = good_cnt + 4'd1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= ST_IDLE;
                lock_cnt <= 4'd0;
                good_cnt <= 4'd0;
                err_cnt  <= 3'd0;
                lost_q   <= 1'b0;
            end else begin
                state    <= state_nxt;
                lock_cnt <= lock_cnt_nxt;
                good_cnt <= good_cnt_nxt;
                err_cnt  <= err_cnt_nxt;
                lost_q   <= lost_nxt;
            end
        end

        assign lane_aligned[l]       = (state == ST_LOCKED);
        assign align_lost[l]         = lost_q;
        assign err_count[l*3 +: 3]   = err_cnt;
    end

    // Disabled lanes count as aligned so they never hold realignment on.
    assign unaligned_any = (|enable) & ~(&(lane_aligned | ~enable));
    assign all_aligned   = (|enable) & (&(lane_aligned | ~enable));

    always_ff @(posedge clk) begin
        if (reset) begin
            patternalign_en <= 1'b0;
        end else begin
            patternalign_en <= unaligned_any;
        end
    end

endmodule

// File: doc/jesd204_soft_pcs_rx_sync_ctrl.md
Name: jesd204_soft_pcs_rx_sync_ctrl

Overview:
Per-lane code-group synchronisation controller for the soft 8b10b RX PCS.
- Watches the registered decoder outputs (char/charisk/notintable/disperr) of every lane.
- Declares each lane aligned once it sees a run of clean K28.5 beats.
- Drives the shared patternalign_en back into the PCS while any enabled lane is unaligned.
- Drops a lane out of alignment when its decode errors accumulate past a threshold.
Sits between the soft PCS RX and the JESD204 link-layer RX.

Parameters:
NUM_LANES, 1, number of lanes.
DATA_PATH_WIDTH, 4, octets per lane per beat.
LOCK_COUNT, 4, consecutive clean comma beats to declare alignment (2..15).
ERR_THRESHOLD, 3, error-count value that forces loss of alignment (1..7).
GOOD_RUN, 4, consecutive clean beats that decrement the error count (1..15).

Ports:
clk  input  1  PCS clock; the only clock.
reset  input  1  synchronous, active-high reset.
enable  input  NUM_LANES  per-lane enable; low holds the lane in IDLE.
char  input  NUM_LANES*DATA_PATH_WIDTH*8  decoded octets.
charisk  input  NUM_LANES*DATA_PATH_WIDTH  control-character flags.
notintable  input  NUM_LANES*DATA_PATH_WIDTH  invalid code-group flags.
disperr  input  NUM_LANES*DATA_PATH_WIDTH  disparity error flags.
patternalign_en  output  1  to PCS; request comma realignment.
lane_aligned  output  NUM_LANES  lane is in LOCKED.
all_aligned  output  1  every enabled lane is aligned and at least one lane is enabled.
align_lost  output  NUM_LANES  one-cycle pulse on LOCKED->SEARCH.
err_count  output  NUM_LANES*3  current per-lane error count.

Behaviour:
Per-beat classification (combinational, per lane):
- err_beat: any octet has notintable|disperr.
- comma_beat: every octet has charisk=1, char=8'hBC, and it is not an err_beat.
- clean_beat: not err_beat.

Per-lane FSM, updated on every clk, registered:
- IDLE: entered on reset or when enable[l]=0 (from any state, highest priority after reset). Goes to SEARCH when enable[l]=1.
- SEARCH:
  - comma_beat -> CHECK with lock_cnt=1.
  - Otherwise stay.
- CHECK:
  - comma_beat -> lock_cnt+1; on reaching LOCK_COUNT go to LOCKED, clear err_cnt and good_cnt.
  - Any beat that is not a comma_beat (including an err_beat) -> SEARCH, lock_cnt=0.
- LOCKED:
  - err_beat: err_cnt+1, good_cnt=0.
  - clean_beat: good_cnt+1. When good_cnt reaches GOOD_RUN: good_cnt=0 and err_cnt-1 if nonzero (saturate at 0).
  - If the incremented err_cnt equals ERR_THRESHOLD: go to SEARCH, pulse align_lost for one cycle, clear counters.
  - Commas are not required in LOCKED; data beats count as clean.

Outputs:
- lane_aligned[l] = (state==LOCKED), registered, so it is valid in the cycle after the transition edge.
- patternalign_en is registered from (|enable) & ~&(lane_aligned | ~enable). It lags lane_aligned by one cycle.
- all_aligned uses the same term as patternalign_en, inverted and gated by |enable.

Reset values:
- State IDLE; all counters 0.
- lane_aligned=0, align_lost=0, err_count=0, patternalign_en=0, all_aligned=0.

Latency and precedence:
- Input beat at edge n -> state/lane_aligned at edge n+1 -> patternalign_en at edge n+2.
- Precedence: reset > enable low > err_beat > comma/clean rules.
- Mid-operation reset or enable drop abandons counters immediately; no align_lost pulse is generated.
- Lanes are independent. Realignment triggered by one lane does not reset the others. A locked lane that is disturbed by the realign shift is handled by its own error counting.

Test Plan:
1. Single lane, reset then enable=1, 4 beats of {BC,BC,BC,BC} with charisk=4'hF -> lane_aligned=1 at edge 5 after the first comma; patternalign_en 1 -> 0 one cycle later; all_aligned=1.
2. CHECK interrupted: 2 comma beats, then a beat with disperr=4'b0010 -> returns to SEARCH. Then 4 comma beats -> LOCKED; total 7 beats before lane_aligned.
3. LOCKED, 3 err_beats separated by 2 clean beats (ERR_THRESHOLD=3, GOOD_RUN=4) -> err_count 1, 2, then align_lost pulses for one cycle, lane_aligned=0, patternalign_en=1 two cycles after the third error.
4. LOCKED, err_beat, then 4 clean beats, then err_beat -> err_count 1 -> 0 -> 1; no loss of alignment. Simultaneous notintable+disperr in one beat counts once.
5. NUM_LANES=2: lane0 locked, lane1 enable=0 -> all_aligned=1, patternalign_en=0. Enable lane1 -> patternalign_en=1 until lane1 locks; lane0 stays aligned.
6. reset asserted while CHECK with lock_cnt=3 -> all outputs at reset values next cycle. After release, the full LOCK_COUNT of comma beats is required again.
